// File: rtl/ternary_matvec_tiled.sv
// Tiled ternary matrix-vector engine: y = W*x with W in {-1,0,+1}, LANES
// columns per cycle, wide accumulation, one final saturation, optional ReLU,
// optional accumulate onto the previous result, and per-row clamp flags.
`timescale 1ns/1ps

module ternary_matvec_tiled #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int LANES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [COLS*WIDTH-1:0]    vector_i,
  input  logic [ROWS*COLS*2-1:0]   matrix_i,
  input  logic                     accumulate_i,
  input  logic                     relu_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [ROWS*WIDTH-1:0]    vector_o,
  output logic [ROWS-1:0]          sat_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i
);

  localparam int BEATS  = COLS / LANES;
  // Worst case |sum| is COLS*2^(WIDTH-1) plus a WIDTH-bit starting value,
  // which fits in this width, so the accumulator itself never wraps.
  localparam int ACC_W  = WIDTH + $clog2(COLS) + 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t SAT_MAX = acc_t'({1'b0, {(WIDTH-1){1'b1}}});
  localparam acc_t SAT_MIN = acc_t'($signed({1'b1, {(WIDTH-1){1'b0}}}));

  state_e                  state_q;
  logic [BEAT_W-1:0]       beat_q;
  acc_t                    acc_q    [ROWS];
  acc_t                    acc_d    [ROWS];
  acc_t                    acc_init [ROWS];
  logic [COLS*WIDTH-1:0]   x_q;
  logic [ROWS*COLS*2-1:0]  w_q;
  logic                    relu_q;
  logic [ROWS*WIDTH-1:0]   y_d;
  logic [ROWS-1:0]         sat_d;
  logic                    accept;

  // Handshake decode: valid from registered state, ready passes out_ready_i
  // through while a result is being held so a new job can chain behind it.
  assign out_valid_o = (state_q == DONE);
  assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;

  // Starting accumulator value: zero, or the result currently on vector_o.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      acc_init[r] = accumulate_i ? acc_t'($signed(vector_o[r*WIDTH +: WIDTH])) : '0;
    end
  end

  // One beat of ternary MACs: add or subtract the sign-extended lane inputs.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    int   col;
    acc_t xe;
    col = 0;
    xe  = '0;
    for (int r = 0; r < ROWS; r++) begin
      acc_d[r] = acc_q[r];
      for (int l = 0; l < LANES; l++) begin
        col = int'(beat_q) * LANES + l;
        // Widen before negating so -(-2^(WIDTH-1)) is representable.
        xe  = acc_t'($signed(x_q[col*WIDTH +: WIDTH]));
        case (w_q[(r*COLS + col)*2 +: 2])
          2'b01:   acc_d[r] = acc_d[r] + xe;
          2'b11:   acc_d[r] = acc_d[r] - xe;
          default: ;
        endcase
      end
    end
  end

  // Post-processing of the final sums: ReLU first, then a single clamp.
  always_comb begin
    acc_t v;
    v     = '0;
    y_d   = '0;
    sat_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      v = acc_d[r];
      if (relu_q && (v < 0)) v = '0;
      if (v > SAT_MAX) begin
        y_d[r*WIDTH +: WIDTH] = SAT_MAX[WIDTH-1:0];
        sat_d[r]              = 1'b1;
      end else if (v < SAT_MIN) begin
        y_d[r*WIDTH +: WIDTH] = SAT_MIN[WIDTH-1:0];
        sat_d[r]              = 1'b1;
      end else begin
        y_d[r*WIDTH +: WIDTH] = v[WIDTH-1:0];
      end
    end
  end

  // Operand capture on accept, so upstream may change inputs during RUN.
  // NOTE: these registers carry no reset; every accept reloads all of them
  // before any use, so a reset would only add routing and buys nothing.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      x_q    <= vector_i;
      w_q    <= matrix_i;
      relu_q <= relu_i;
    end
  end

  // Control FSM, accumulators and the registered result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      vector_o <= '0;
      sat_o    <= '0;
      for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            beat_q  <= '0;
            for (int r = 0; r < ROWS; r++) acc_q[r] <= acc_init[r];
          end
        end
        RUN: begin
          for (int r = 0; r < ROWS; r++) acc_q[r] <= acc_d[r];
          beat_q <= beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            vector_o <= y_d;
            sat_o    <= sat_d;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (accept) begin
            state_q <= RUN;
            beat_q  <= '0;
            for (int r = 0; r < ROWS; r++) acc_q[r] <= acc_init[r];
          end else if (out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_matvec_tiled.sv
// Self-checking bench for ternary_matvec_tiled: three instances (LANES=1,2,4)
// with WIDTH=8, ROWS=2, COLS=4, a reference model and a result scoreboard.
`timescale 1ns/1ps

module tb_ternary_matvec_tiled;

  localparam int TW = 8;
  localparam int TR = 2;
  localparam int TC = 4;
  localparam int NI = 3;
  localparam int XW = TC*TW;
  localparam int MW = TR*TC*2;
  localparam int YW = TR*TW;

  localparam logic [1:0] P  = 2'b01;
  localparam logic [1:0] N  = 2'b11;
  localparam logic [1:0] Z  = 2'b00;
  localparam logic [1:0] Z2 = 2'b10;

  typedef struct packed {
    logic [YW-1:0] vec;
    logic [TR-1:0] sat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [XW-1:0] vector_i = '0;
  logic [MW-1:0] matrix_i = '0;
  logic          accumulate_i = 1'b0;
  logic          relu_i = 1'b0;
  logic          in_valid  [NI];
  logic          out_ready [NI];
  logic          in_ready  [NI];
  logic          out_valid [NI];
  logic [YW-1:0] vec_o     [NI];
  logic [TR-1:0] sat_w     [NI];

  int            n_run = 0;
  int            n_fail = 0;
  int            cur = 1;
  bit            rand_ready = 1'b0;
  exp_t          sb_q[$];
  logic [YW-1:0] model_last [NI];
  longint        cyc = 0;
  longint        last_acc_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ternary_matvec_tiled #(
      .WIDTH(TW), .ROWS(TR), .COLS(TC), .LANES(1 << g)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .vector_i     (vector_i),
      .matrix_i     (matrix_i),
      .accumulate_i (accumulate_i),
      .relu_i       (relu_i),
      .in_valid_i   (in_valid[g]),
      .in_ready_o   (in_ready[g]),
      .vector_o     (vec_o[g]),
      .sat_o        (sat_w[g]),
      .out_valid_o  (out_valid[g]),
      .out_ready_i  (out_ready[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input logic [XW-1:0] x, input logic [MW-1:0] w,
                                 input logic acc, input logic relu,
                                 input logic [YW-1:0] prev);
    exp_t e;
    int   s;
    int   xv;
    int   maxv;
    int   minv;
    maxv = (1 << (TW-1)) - 1;
    minv = -(1 << (TW-1));
    e    = '0;
    for (int r = 0; r < TR; r++) begin
      s = acc ? int'($signed(prev[r*TW +: TW])) : 0;
      for (int c = 0; c < TC; c++) begin
        xv = int'($signed(x[c*TW +: TW]));
        if (w[(r*TC+c)*2 +: 2] == 2'b01) s = s + xv;
        else if (w[(r*TC+c)*2 +: 2] == 2'b11) s = s - xv;
      end
      if (relu && s < 0) s = 0;
      if (s > maxv) begin
        s = maxv;
        e.sat[r] = 1'b1;
      end else if (s < minv) begin
        s = minv;
        e.sat[r] = 1'b1;
      end
      e.vec[r*TW +: TW] = TW'(s);
    end
    return e;
  endfunction

  function automatic logic [XW-1:0] mk_x4(input int a, input int b, input int c, input int d);
    return {TW'(d), TW'(c), TW'(b), TW'(a)};
  endfunction

  function automatic logic [TC*2-1:0] mk_row(input logic [1:0] c0, input logic [1:0] c1,
                                             input logic [1:0] c2, input logic [1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic jitter();
    if (rand_ready) out_ready[cur] = ($urandom_range(0, 3) != 0);
  endtask

  // Scoreboard: pop and compare on every output handshake of the active DUT.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid[cur] && out_ready[cur]) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_vector", 32'(vec_o[cur]), 32'(e.vec));
        check("sb_sat", 32'(sat_w[cur]), 32'(e.sat));
      end
    end
  end

  // Present one operand set, wait for accept, push the expected result.
  task automatic send(input int idx, input logic [XW-1:0] x, input logic [MW-1:0] w,
                      input logic acc, input logic relu, input bit gap_chk);
    exp_t e;
    int   n;
    vector_i      = x;
    matrix_i      = w;
    accumulate_i  = acc;
    relu_i        = relu;
    in_valid[idx] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready[idx]) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid[idx] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      jitter();
    end
    @(posedge clk);
    e = model(x, w, acc, relu, model_last[idx]);
    sb_q.push_back(e);
    model_last[idx] = e.vec;
    #1;
    if (gap_chk) check("b2b_gap", 32'(cyc - last_acc_cyc), 32'((TC >> idx) + 1));
    last_acc_cyc  = cyc;
    in_valid[idx] = 1'b0;
    jitter();
  endtask

  task automatic drain(input int idx);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      jitter();
      n++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    out_ready[idx] = 1'b1;
  endtask

  task automatic expect_latency(input int idx, input int exp_n);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!out_valid[idx] && n < 20);
    check("out_valid_latency", 32'(n), 32'(exp_n));
  endtask

  task automatic check_reset_state(input int idx);
    check("rst_out_valid", 32'(out_valid[idx]), 32'd0);
    check("rst_in_ready", 32'(in_ready[idx]), 32'd1);
    check("rst_vector", 32'(vec_o[idx]), 32'd0);
    check("rst_sat", 32'(sat_w[idx]), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XW-1:0] x_b;
    logic [MW-1:0] w_b;
    for (int i = 0; i < NI; i++) begin
      in_valid[i]   = 1'b0;
      out_ready[i]  = 1'b1;
      model_last[i] = '0;
    end
    x_b = mk_x4(1, 2, 3, 4);
    w_b = {mk_row(N, Z, P, Z), mk_row(P, P, P, P)};

    // Reset state on every instance.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check_reset_state(i);
    rst_n = 1'b1;
    cur   = 1;

    // Basic result with latency, then 5 cycles of backpressure.
    out_ready[1] = 1'b0;
    send(1, x_b, w_b, 1'b0, 1'b0, 1'b0);
    expect_latency(1, 2);
    repeat (5) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid[1]), 32'd1);
      check("hold_in_ready", 32'(in_ready[1]), 32'd0);
      check("hold_vector", 32'(vec_o[1]), 32'h020A);
      check("hold_sat", 32'(sat_w[1]), 32'd0);
    end

    // Handoff plus accumulate in the same cycle; scramble inputs during RUN.
    @(posedge clk);
    #1;
    out_ready[1] = 1'b1;
    send(1, x_b, w_b, 1'b1, 1'b0, 1'b0);
    vector_i = mk_x4(-7, 55, 99, -128);
    matrix_i = '1;
    expect_latency(1, 2);
    check("accum_vector", 32'(vec_o[1]), 32'h0414);
    drain(1);

    // Saturation, back-to-back: positive/negative clamp, then -128 negated.
    send(1, mk_x4(100, 100, 100, 100), {mk_row(N, N, N, N), mk_row(P, P, P, P)}, 1'b0, 1'b0, 1'b0);
    send(1, mk_x4(-128, -128, -128, -128), {mk_row(P, P, P, P), mk_row(N, N, N, N)}, 1'b0, 1'b0, 1'b1);
    // ReLU zeroing (row1 = -5) without a saturation flag.
    send(1, x_b, {mk_row(N, Z, Z, N), mk_row(P, P, P, P)}, 1'b0, 1'b1, 1'b1);
    // Weight code 2'b10 must behave as zero.
    send(1, x_b, {mk_row(P, Z2, N, Z2), mk_row(Z2, Z2, Z2, Z2)}, 1'b0, 1'b0, 1'b1);
    drain(1);
    check("w10_vector", 32'(vec_o[1]), 32'hFE00);

    // Reset in the middle of RUN (at beat 1), then a fresh accumulate.
    send(1, x_b, w_b, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state(1);
    sb_q.delete();
    for (int i = 0; i < NI; i++) model_last[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1, x_b, w_b, 1'b1, 1'b0, 1'b0);
    drain(1);

    // Random sweep on each LANES variant with random output backpressure.
    for (int idx = 0; idx < NI; idx++) begin
      cur        = idx;
      rand_ready = 1'b1;
      for (int k = 0; k < 1000; k++) begin
        send(idx, XW'($urandom()), MW'($urandom()), ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)), 1'b0);
      end
      drain(idx);
      rand_ready     = 1'b0;
      out_ready[idx] = 1'b1;
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
